ifu_fetch: RTL
==============

Name: ifu_fetch

Overview:
- Instruction-fetch stage of the multicycle CPU.
- Holds the architectural PC and loads it with the next-PC value computed by the next-PC logic when control asserts pc_wr.
- Fetches the instruction at PC from instruction memory over a variable-latency req/ready handshake and latches it into the instruction register (IR).
- pc_out feeds back to the next-PC logic as the current PC; ir_out feeds decode.

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset.
TIMEOUT_CYCLES, 16, maximum wait cycles for imem_ready (used only with IFU_TIMEOUT_EN); legal range 1..255.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
pc_wr  in  1  load pc_next into PC this cycle.
pc_next  in  32  next PC from next-PC logic.
fetch_req  in  1  control request to fetch at current PC; single-cycle pulse.
fetch_done  out  1  one-cycle pulse: IR holds the new instruction.
busy  out  1  high in any state other than IDLE.
pc_out  out  32  current PC.
ir_out  out  32  instruction register.
imem_req  out  1  memory request, registered.
imem_addr  out  32  memory word address, registered.
imem_ready  in  1  memory has valid data on imem_rdata this cycle.
imem_rdata  in  32  instruction data.
misalign_err  out  1  sticky flag: a misaligned pc_next was loaded.
fetch_err  out  1  one-cycle timeout pulse (tied 0 without IFU_TIMEOUT_EN).

Behaviour:
- Reset, asynchronous on rst_n low:
  - pc_out=RESET_PC, ir_out=0, imem_req=0, imem_addr=0.
  - fetch_done=0, busy=0, misalign_err=0, fetch_err=0.
  - State=IDLE; timeout counter=0.
  - Reset mid-fetch abandons the transaction: imem_req drops immediately and any late imem_ready is ignored.
- PC update:
  - On a clk edge with pc_wr=1: pc_out <= {pc_next[31:2],2'b00}.
  - If pc_next[1:0]!=0, misalign_err is set; it clears only on reset.
  - pc_wr is honoured in every state.
- FSM states: IDLE, REQ, DONE.
  - IDLE: on fetch_req=1 -> REQ; imem_req<=1; imem_addr<=PC value after this edge (pc_next aligned if pc_wr is also 1, else current PC). fetch_req is ignored in REQ and DONE.
  - REQ: imem_req held at 1 and imem_addr held stable until the handshake completes. On imem_ready=1: ir_out<=imem_rdata, imem_req<=0, -> DONE. A pc_wr during REQ updates pc_out but does not change imem_addr.
  - DONE: fetch_done=1 for exactly this cycle, -> IDLE. A fetch_req arriving in DONE is dropped; control must re-issue it in IDLE.
- Latency: fetch_req at cycle 0 -> imem_req high from cycle 1. With imem_ready in cycle 1, ir_out updates at the end of cycle 1 and fetch_done is high in cycle 2. Each extra wait cycle adds one cycle.
- ir_out changes only on a completed handshake (or on timeout, with the feature enabled); otherwise it holds.
- imem_ready while imem_req=0 is ignored.

Optional Feature:
IFU_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on entry to REQ and increments on every REQ cycle without imem_ready.
  - When it reaches TIMEOUT_CYCLES: ir_out<=32'h0000_0000 (NOP), imem_req<=0, fetch_err pulses high for 1 cycle together with the DONE cycle, -> DONE.
  - imem_ready arriving in the same cycle as the timeout wins: normal completion, no fetch_err.
- Undefined: no counter; REQ waits indefinitely; fetch_err is constant 0.

Test Plan:
- Reset release, no activity -> pc_out=0x00003000, ir_out=0, busy=0, imem_req=0.
- fetch_req cycle 0, imem_ready=1 with rdata=0x8C010004 in cycle 1 -> imem_addr=0x00003000 in cycle 1, ir_out=0x8C010004 and fetch_done=1 in cycle 2, busy=0 in cycle 3.
- fetch_req with imem_ready delayed 3 cycles; pc_wr pc_next=0x00003010 during REQ -> imem_addr stays 0x00003000 throughout, pc_out=0x00003010, fetch_done 4 cycles after imem_req rose.
- pc_wr with pc_next=0x00003006 -> pc_out=0x00003004, misalign_err=1 and still set after a following clean fetch.
- rst_n low for 1 cycle during REQ, then imem_ready pulse -> imem_req=0 immediately, pc_out=0x00003000, no fetch_done, ir_out=0.
- IFU_TIMEOUT_EN with TIMEOUT_CYCLES=4, imem_ready never asserted -> after 4 REQ cycles: ir_out=0, fetch_err=1 and fetch_done=1 in the same cycle, then IDLE.

Source files
------------

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch stage of the multicycle CPU.
// Holds the architectural PC and fetches the instruction at PC over a
// variable-latency req/ready handshake into the instruction register.
// Optional build macro IFU_TIMEOUT_EN: abandons a fetch after TIMEOUT_CYCLES
// wait cycles, loads a NOP into IR and pulses fetch_err.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_3000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_wr,
  input  logic [31:0] pc_next,
  input  logic        fetch_req,
  output logic        fetch_done,
  output logic        busy,
  output logic [31:0] pc_out,
  output logic [31:0] ir_out,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        misalign_err,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_aligned;
  logic [31:0] pc_after;
  logic        accept;
  logic        complete;
  logic        tmo_hit;

  // The PC is always word aligned; low bits of pc_next only feed the error flag.
  assign pc_aligned = {pc_next[31:2], 2'b00};
  // Address of the fetch: the PC value that will be current after this edge.
  assign pc_after   = pc_wr ? pc_aligned : pc_q;
  assign accept     = (state_q == IDLE) && fetch_req;
  // imem_ready only counts while a request is outstanding (REQ).
  assign complete   = (state_q == REQ) && imem_ready;

`ifdef IFU_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tmo_cnt;
  logic       err_q;

  // A ready in the final wait cycle takes priority over the timeout.
  assign tmo_hit = (state_q == REQ) && !imem_ready && (tmo_cnt == TMO_LAST);

  // Wait-cycle counter: cleared when a fetch starts, counts unanswered REQ cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= 8'd0;
    end else if (accept) begin
      tmo_cnt <= 8'd0;
    end else if ((state_q == REQ) && !imem_ready) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  // Error pulse lines up with the DONE cycle that follows a timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= tmo_hit;
    end
  end

  assign fetch_err = err_q;
`else
  logic [7:0] unused_tmo_cycles;

  assign unused_tmo_cycles = 8'(TIMEOUT_CYCLES);
  assign tmo_hit           = 1'b0;
  assign fetch_err         = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state logic; fetch_req is only looked at in IDLE.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fetch_req) state_d = REQ;
      REQ:     if (imem_ready || tmo_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Architectural PC and sticky misalignment flag; pc_wr wins in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      misalign_err <= 1'b0;
    end else if (pc_wr) begin
      pc_q <= pc_aligned;
      if (pc_next[1:0] != 2'b00) misalign_err <= 1'b1;
    end
  end

  // Memory request, address and instruction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_req  <= 1'b0;
      imem_addr <= 32'd0;
      ir_out    <= 32'd0;
    end else if (accept) begin
      imem_req  <= 1'b1;
      imem_addr <= pc_after;
    end else if (complete) begin
      imem_req <= 1'b0;
      ir_out   <= imem_rdata;
    end else if (tmo_hit) begin
      imem_req <= 1'b0;
      ir_out   <= 32'h0000_0000;
    end
  end

  assign pc_out     = pc_q;
  assign fetch_done = (state_q == DONE);
  assign busy       = (state_q != IDLE);

endmodule
